// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and bit-period helper.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StStart  = START,
    StData   = DATA,
    StParity = PARITY,
    StStop   = STOP
  } uart_state_e;

  // Clock cycles per bit; shared with the receiver so both ends agree.
  function automatic int unsigned bit_period(input int unsigned clkfreq,
                                             input int unsigned speed);
    return clkfreq / speed;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the host and the UART transmitter.
interface uart_tx_if;
  logic       wvalid;
  logic [7:0] word;
  logic       wready;

  modport master (output wvalid, output word, input wready);
  modport slave  (input wvalid, input word, output wready);
endinterface

// File: rtl/uart_bit_timer.sv
// Restartable 16-bit bit timer; tick is high on the last cycle of each bit period.
module uart_bit_timer #(
  parameter int unsigned BIT_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic tick
);

  localparam logic [15:0] Last = 16'(BIT_PERIOD - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (start || (cnt_q == Last)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == Last);

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter, LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned SPEED     = 32'd31500,
  parameter int unsigned CLKFREQ   = 32'd10000000,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  tx_if,
  output logic      busy,
  output logic      uart_out
);

  localparam int unsigned BIT_PERIOD = bit_period(CLKFREQ, SPEED);

  if (BIT_PERIOD < 2 || BIT_PERIOD > 65535) begin : g_bad_period
    $error("uart_tx: BIT_PERIOD must be within 2..65535");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        out_q, out_d;
  logic        wready, accept, timer_start, tick;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign wready       = (state_q == StIdle) && !rst;
  assign tx_if.wready = wready;
  assign accept       = tx_if.wvalid && wready;

  uart_bit_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .start(timer_start),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    out_d       = out_q;
    timer_start = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        out_d = 1'b1;
        if (accept) begin
          state_d     = StStart;
          shift_d     = tx_if.word;
          bitcnt_d    = '0;
          out_d       = 1'b0;
          timer_start = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d    = ^tx_if.word;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          out_d   = shift_q[0];
        end
      end
      StData: begin
        if (tick) begin
          if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            out_d   = parity_q;
`else
            state_d  = StStop;
            out_d    = 1'b1;
            bitcnt_d = '0;
`endif
          end else begin
            shift_d  = {1'b0, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            out_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d  = StStop;
          out_d    = 1'b1;
          bitcnt_d = '0;
        end
      end
`endif
      StStop: begin
        // bitcnt counts completed stop bits here
        if (tick) begin
          if (bitcnt_q == LastStop) state_d  = StIdle;
          else                      bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        out_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      bitcnt_q <= '0;
      out_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      out_q    <= out_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign busy     = (state_q != StIdle);
  assign uart_out = out_q;

endmodule
